// File: rtl/rx_ctrl_pkg.sv
// Shared types and helpers for the receive drain controller: drain FSM states,
// byte width, requester count and the two-way round-robin pick.
package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } drain_state_t;

  localparam int RX_BYTE_W = 8;
  localparam int N_REQ     = 2;

  // One-hot grant: the favoured requester if it asks, otherwise the other one.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                               input logic             ptr);
    logic [N_REQ-1:0] g;
    g = '0;
    if (req_v[ptr]) begin
      g[ptr] = 1'b1;
    end else if (req_v[~ptr]) begin
      g[~ptr] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock byte FIFO with registered count/full/empty flags.
// Head entry is presented combinationally; a push never bypasses to the read side.
module rx_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_INC = AW'(1);
  localparam logic [CW-1:0] CNT_INC = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // Flags gate the strobes so a stray request can never corrupt pointers.
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_INC;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_INC;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_INC;
      2'b01:   count_d = count_q - CNT_INC;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_MAX);
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/rx_drain_ctrl.sv
// Drains receiver bytes into a FIFO with a data_ready/data_read handshake,
// shares them between two consumers round-robin, and counts receiver errors.
module rx_drain_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_data_ready,
  input  logic [RX_BYTE_W-1:0]         rx_data,
  input  logic                         rx_overrun,
  input  logic                         rx_framing,
  output logic                         rx_data_read,
  input  logic [N_REQ-1:0]             req,
  output logic [N_REQ-1:0]             gnt,
  output logic                         rd_valid,
  output logic [RX_BYTE_W-1:0]         rd_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic [ERR_CNT_W-1:0]         overrun_cnt,
  output logic [ERR_CNT_W-1:0]         framing_cnt,
  input  logic                         clr_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_ONE;
  endfunction

  drain_state_t           state_q, state_d;
  logic                   push, pop;
  logic                   rx_data_read_q;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic                   rd_valid_q;
  logic [RX_BYTE_W-1:0]   rd_data_q, rd_data_d;
  logic                   rr_ptr_q, rr_ptr_d;
  logic [RX_BYTE_W-1:0]   fifo_rdata;
  logic                   ovr_dly_q, frm_dly_q;
  logic [ERR_CNT_W-1:0]   ovr_cnt_q, ovr_cnt_d;
  logic [ERR_CNT_W-1:0]   frm_cnt_q, frm_cnt_d;

  rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (RX_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (rx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Registered flags decide pop; a byte pushed this edge is not poppable until the next.
  assign pop = ~fifo_empty & (req != '0);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_data_ready && !fifo_full) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        // Hold off until the receiver drops ready so one byte is never captured twice.
        if (!rx_data_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_d     = '0;
    rr_ptr_d  = rr_ptr_q;
    rd_data_d = rd_data_q;
    if (pop) begin
      gnt_d     = rr_pick(req, rr_ptr_q);
      rr_ptr_d  = gnt_d[0];
      rd_data_d = fifo_rdata;
    end
  end

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (clr_cnt) begin
      ovr_cnt_d = '0;
      frm_cnt_d = '0;
    end else begin
      if (rx_overrun && !ovr_dly_q) begin
        ovr_cnt_d = sat_inc(ovr_cnt_q);
      end
      if (rx_framing && !frm_dly_q) begin
        frm_cnt_d = sat_inc(frm_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rx_data_read_q <= 1'b0;
      gnt_q          <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      rr_ptr_q       <= 1'b0;
      ovr_dly_q      <= 1'b0;
      frm_dly_q      <= 1'b0;
      ovr_cnt_q      <= '0;
      frm_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      rx_data_read_q <= push;
      gnt_q          <= gnt_d;
      rd_valid_q     <= pop;
      rd_data_q      <= rd_data_d;
      rr_ptr_q       <= rr_ptr_d;
      ovr_dly_q      <= rx_overrun;
      frm_dly_q      <= rx_framing;
      ovr_cnt_q      <= ovr_cnt_d;
      frm_cnt_q      <= frm_cnt_d;
    end
  end

  assign rx_data_read = rx_data_read_q;
  assign gnt          = gnt_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign overrun_cnt  = ovr_cnt_q;
  assign framing_cnt  = frm_cnt_q;

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Directed bench for rx_drain_ctrl: a queue-based reference model checked every cycle,
// plus literal expectations for the handshake, arbitration and counter scenarios.
module tb_rx_drain_ctrl;

  localparam int D  = 8;
  localparam int EW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_data_ready;
  logic [7:0]   rx_data;
  logic         rx_overrun;
  logic         rx_framing;
  logic         rx_data_read;
  logic [1:0]   req;
  logic [1:0]   gnt;
  logic         rd_valid;
  logic [7:0]   rd_data;
  logic [3:0]   fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic [EW-1:0] overrun_cnt;
  logic [EW-1:0] framing_cnt;
  logic         clr_cnt;

  always #5 clk = ~clk;

  rx_drain_ctrl #(.FIFO_DEPTH(D), .ERR_CNT_W(EW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .rx_overrun    (rx_overrun),
    .rx_framing    (rx_framing),
    .rx_data_read  (rx_data_read),
    .req           (req),
    .gnt           (gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .fifo_count    (fifo_count),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .overrun_cnt   (overrun_cnt),
    .framing_cnt   (framing_cnt),
    .clr_cnt       (clr_cnt)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: byte queue, favoured requester, handshake phase, counters.
  logic [7:0] mq[$];
  int         m_phase;   // 0 ready to take, 1 acking, 2 waiting for ready to drop
  int         m_rr;
  logic       m_ack;
  logic [1:0] m_gnt;
  logic       m_vld;
  logic [7:0] m_data;
  int         m_ovr, m_frm;
  logic       m_ovr_prev, m_frm_prev;

  // Simple receiver: offers queued bytes, drops ready on ack, stays low two cycles.
  logic [7:0] txq[$];
  bit         rcv_auto;
  int         gap;

  int acks, ack_at, vld_at;
  logic [7:0] t3_data [4];
  logic [1:0] t3_gnt  [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit do_push;
    bit do_pop;
    int who;
    if (rst) begin
      mq.delete();
      m_phase = 0; m_rr = 0;
      m_ack = 1'b0; m_gnt = 2'b00; m_vld = 1'b0; m_data = 8'h00;
      m_ovr = 0; m_frm = 0; m_ovr_prev = 1'b0; m_frm_prev = 1'b0;
    end else begin
      do_push = (m_phase == 0) && rx_data_ready && (mq.size() < D);
      do_pop  = (mq.size() > 0) && (req != 2'b00);
      m_ack = do_push;
      m_vld = do_pop;
      m_gnt = 2'b00;
      if (do_pop) begin
        if (req == 2'b11) who = m_rr;
        else              who = req[1] ? 1 : 0;
        m_gnt[who] = 1'b1;
        m_data = mq.pop_front();
        m_rr = 1 - who;
      end
      if (do_push) mq.push_back(rx_data);
      if (m_phase == 0)      m_phase = do_push ? 1 : 0;
      else if (m_phase == 1) m_phase = 2;
      else                   m_phase = rx_data_ready ? 2 : 0;
      if (clr_cnt) begin
        m_ovr = 0;
        m_frm = 0;
      end else begin
        if (rx_overrun && !m_ovr_prev && m_ovr < 255) m_ovr++;
        if (rx_framing && !m_frm_prev && m_frm < 255) m_frm++;
      end
      m_ovr_prev = rx_overrun;
      m_frm_prev = rx_framing;
    end
  endtask

  task automatic compare();
    if (!chk_en) return;
    check("rx_data_read", rx_data_read, m_ack);
    check("gnt", gnt, m_gnt);
    check("rd_valid", rd_valid, m_vld);
    if (m_vld) check("rd_data", rd_data, m_data);
    check("fifo_count", fifo_count, mq.size());
    check("fifo_full", fifo_full, mq.size() == D);
    check("fifo_empty", fifo_empty, mq.size() == 0);
    check("overrun_cnt", overrun_cnt, m_ovr);
    check("framing_cnt", framing_cnt, m_frm);
  endtask

  task automatic rcv_update();
    if (!rcv_auto) return;
    if (rx_data_read) begin
      rx_data_ready = 1'b0;
      void'(txq.pop_front());
      gap = 2;
    end else if (!rx_data_ready) begin
      if (gap > 0) gap--;
      if (gap == 0 && txq.size() > 0) begin
        rx_data_ready = 1'b1;
        rx_data       = txq[0];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    rcv_update();
  endtask

  task automatic drain();
    req = 2'b01;
    for (int i = 0; i < 30 && !fifo_empty; i++) tick();
    req = 2'b00;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_data_ready = 1'b0; rx_data = 8'h00; rx_overrun = 1'b0;
    rx_framing = 1'b0; req = 2'b00; clr_cnt = 1'b0; rcv_auto = 1'b1; gap = 0;
    t3_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    t3_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_empty", fifo_empty, 1);
    check("reset_count", fifo_count, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_ack", rx_data_read, 0);
    rst = 1'b0;

    // Single byte through to consumer 0
    req = 2'b01;
    txq.push_back(8'hA5);
    acks = 0; ack_at = -1; vld_at = -1;
    for (int i = 0; i < 20 && vld_at < 0; i++) begin
      tick();
      if (rx_data_read) begin acks++; ack_at = i; end
      if (rd_valid) begin
        vld_at = i;
        check("t1_gnt", gnt, 2'b01);
        check("t1_rd_data", rd_data, 8'hA5);
      end
    end
    check("t1_seen_valid", vld_at >= 0, 1);
    check("t1_ack_to_valid", vld_at - ack_at, 1);
    check("t1_acks", acks, 1);
    req = 2'b00;
    repeat (4) tick();

    // Fill to full; ninth byte must wait for a pop
    for (int b = 0; b < 9; b++) txq.push_back(8'h10 + 8'(b));
    acks = 0;
    repeat (40) begin tick(); if (rx_data_read) acks++; end
    check("t2_acks_to_full", acks, 8);
    check("t2_full", fifo_full, 1);
    check("t2_count", fifo_count, 8);
    acks = 0;
    repeat (5) begin tick(); if (rx_data_read) acks++; end
    check("t2_held_while_full", acks, 0);
    req = 2'b01;
    tick();
    check("t2_first_pop", rd_data, 8'h10);
    req = 2'b00;
    acks = 0;
    repeat (5) begin tick(); if (rx_data_read) acks++; end
    check("t2_ninth_captured", acks, 1);
    check("t2_count_after", fifo_count, 8);
    drain();
    check("t2_drained", fifo_empty, 1);

    // Round-robin with both consumers requesting
    rst = 1'b1; tick(); rst = 1'b0;
    for (int b = 0; b < 4; b++) txq.push_back(t3_data[b]);
    for (int i = 0; i < 30 && fifo_count != 4; i++) tick();
    repeat (3) tick();
    check("t3_count", fifo_count, 4);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_rd_valid", rd_valid, 1);
      check("t3_gnt", gnt, t3_gnt[k]);
      check("t3_rd_data", rd_data, t3_data[k]);
    end
    req = 2'b00;
    tick();

    // Error counters: edges, clear, saturation, clear priority
    repeat (3) begin rx_framing = 1'b1; tick(); rx_framing = 1'b0; tick(); end
    rx_overrun = 1'b1; repeat (5) tick(); rx_overrun = 1'b0; tick();
    check("t4_framing", framing_cnt, 3);
    check("t4_overrun", overrun_cnt, 1);
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    check("t4_clr_frm", framing_cnt, 0);
    check("t4_clr_ovr", overrun_cnt, 0);
    repeat (300) begin
      rx_framing = 1'b1; rx_overrun = 1'b1; tick();
      rx_framing = 1'b0; rx_overrun = 1'b0; tick();
    end
    check("t4_sat_frm", framing_cnt, 255);
    check("t4_sat_ovr", overrun_cnt, 255);
    rx_framing = 1'b1; clr_cnt = 1'b1; tick();
    check("t4_clr_wins", framing_cnt, 0);
    rx_framing = 1'b0; clr_cnt = 1'b0; tick();

    // Simultaneous push and pop, then push into an empty FIFO
    for (int b = 0; b < 4; b++) txq.push_back(8'h31 + 8'(b));
    for (int i = 0; i < 30 && fifo_count != 4; i++) tick();
    repeat (3) tick();
    rcv_auto = 1'b0;
    rx_data = 8'h55; rx_data_ready = 1'b1; req = 2'b01;
    tick();
    check("t5_count_same", fifo_count, 4);
    check("t5_pop_data", rd_data, 8'h31);
    check("t5_push_ack", rx_data_read, 1);
    rx_data_ready = 1'b0; req = 2'b00;
    repeat (3) tick();
    drain();
    rx_data = 8'h66; rx_data_ready = 1'b1; req = 2'b01;
    tick();
    check("t5_no_pop_when_empty", rd_valid, 0);
    check("t5_count_one", fifo_count, 1);
    rx_data_ready = 1'b0;
    tick();
    check("t5_late_valid", rd_valid, 1);
    check("t5_late_data", rd_data, 8'h66);
    req = 2'b00;
    repeat (3) tick();

    // Reset while acking; held byte captured again exactly once
    rx_data = 8'h77; rx_data_ready = 1'b1;
    tick();
    check("t6_in_ack", rx_data_read, 1);
    rst = 1'b1;
    tick();
    check("t6_rst_ack", rx_data_read, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_gnt", gnt, 0);
    rst = 1'b0;
    acks = 0;
    repeat (4) begin tick(); if (rx_data_read) acks++; end
    check("t6_one_ack", acks, 1);
    check("t6_count", fifo_count, 1);
    rx_data_ready = 1'b0;
    repeat (3) tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
